// File: rtl/fir_pkg.sv
// Shared definitions for the FIR tap ring.
//   fir_state_e : controller states
//   calc_chw    : channel-index width, at least one bit even for a single channel
package fir_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StWrite,
    StRdIssue,
    StRdHold
  } fir_state_e;

  function automatic int unsigned calc_chw(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Single-port sample store with a registered read port.
//   clk_i   : clock
//   we_i    : write enable (takes precedence over read)
//   re_i    : read enable; rdata_o updates one cycle later and holds otherwise
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module sample_ram #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned RAW    = 5,
  parameter int unsigned NWORDS = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [RAW-1:0]    addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [NWORDS];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fir_tap_ring.sv
// Multi-channel FIR delay line. Each accepted sample is written into its
// channel's ring, then the channel's DEPTH taps are streamed newest first.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : sample handshake (ready only in IDLE)
//   in_channel/in_data  : target channel and sample
//   flush               : clear all history and pointers (IDLE only)
//   tap_valid/tap_ready : tap handshake
//   tap_data/tap_index  : delayed sample x[n-k] and its delay k
//   tap_channel/tap_last: stream channel, marks k = DEPTH-1
//   err_channel         : one-cycle pulse when an out-of-range channel is dropped
module fir_tap_ring
  import fir_pkg::*;
#(
  parameter  int unsigned DWIDTH = 8,
  parameter  int unsigned AWIDTH = 4,
  parameter  int unsigned NCH    = 2,
  localparam int unsigned CHW    = calc_chw(NCH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHW-1:0]    in_channel,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              flush,
  output logic              tap_valid,
  input  logic              tap_ready,
  output logic [DWIDTH-1:0] tap_data,
  output logic [AWIDTH-1:0] tap_index,
  output logic [CHW-1:0]    tap_channel,
  output logic              tap_last,
  output logic              err_channel
);

  localparam int unsigned DEPTH  = 2 ** AWIDTH;
  localparam int unsigned NWORDS = NCH * DEPTH;
  // Address is {channel, slot}: ch*DEPTH + slot since DEPTH is a power of two.
  localparam int unsigned RAW    = CHW + AWIDTH;

  fir_state_e        state_q, state_d;
  logic [RAW-1:0]    clr_addr_q, clr_addr_d;
  logic [AWIDTH-1:0] wptr_q [NCH];
  logic [AWIDTH-1:0] wptr_d [NCH];
  logic [CHW-1:0]    cur_ch_q, cur_ch_d;
  logic [DWIDTH-1:0] cur_data_q, cur_data_d;
  logic [AWIDTH-1:0] slot_q, slot_d;
  logic [AWIDTH-1:0] k_q, k_d;
  logic              in_ready_q, in_ready_d;
  logic              tap_valid_q, tap_valid_d;
  logic              tap_last_q, tap_last_d;
  logic              err_q, err_d;

  logic              ram_we, ram_re;
  logic [RAW-1:0]    ram_addr;
  logic [DWIDTH-1:0] ram_wdata, ram_rdata;
  logic [AWIDTH-1:0] rd_slot;

  assign rd_slot = slot_q - k_q;  // wraps mod DEPTH

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    wptr_d     = wptr_q;
    cur_ch_d   = cur_ch_q;
    cur_data_d = cur_data_q;
    slot_d     = slot_q;
    k_d        = k_q;
    err_d      = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_addr   = '0;
    ram_wdata  = '0;

    unique case (state_q)
      StClear: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr_q;
        for (int i = 0; i < NCH; i++) wptr_d[i] = '0;
        if (clr_addr_q == RAW'(NWORDS - 1)) begin
          clr_addr_d = '0;
          state_d    = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      StIdle: begin
        if (flush) begin
          clr_addr_d = '0;
          state_d    = StClear;
        end else if (in_valid) begin
          if (32'(in_channel) < NCH) begin
            cur_ch_d   = in_channel;
            cur_data_d = in_data;
            state_d    = StWrite;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        ram_we              = 1'b1;
        ram_addr            = {cur_ch_q, wptr_q[cur_ch_q]};
        ram_wdata           = cur_data_q;
        slot_d              = wptr_q[cur_ch_q];
        wptr_d[cur_ch_q]    = wptr_q[cur_ch_q] + 1'b1;
        k_d                 = '0;
        state_d             = StRdIssue;
      end
      StRdIssue: begin
        ram_re   = 1'b1;
        ram_addr = {cur_ch_q, rd_slot};
        state_d  = StRdHold;
      end
      StRdHold: begin
        if (tap_ready) begin
          if (k_q == AWIDTH'(DEPTH - 1)) begin
            state_d = StIdle;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = StRdIssue;
          end
        end
      end
      default: begin
        clr_addr_d = '0;
        state_d    = StClear;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    in_ready_d  = (state_d == StIdle);
    tap_valid_d = (state_d == StRdHold);
    tap_last_d  = (state_d == StRdHold) && (k_d == AWIDTH'(DEPTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StClear;
      clr_addr_q  <= '0;
      for (int i = 0; i < NCH; i++) wptr_q[i] <= '0;
      cur_ch_q    <= '0;
      cur_data_q  <= '0;
      slot_q      <= '0;
      k_q         <= '0;
      in_ready_q  <= 1'b0;
      tap_valid_q <= 1'b0;
      tap_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      wptr_q      <= wptr_d;
      cur_ch_q    <= cur_ch_d;
      cur_data_q  <= cur_data_d;
      slot_q      <= slot_d;
      k_q         <= k_d;
      in_ready_q  <= in_ready_d;
      tap_valid_q <= tap_valid_d;
      tap_last_q  <= tap_last_d;
      err_q       <= err_d;
    end
  end

  sample_ram #(
    .DWIDTH (DWIDTH),
    .RAW    (RAW),
    .NWORDS (NWORDS)
  ) u_sample_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // RAM read data only holds a tap in RD_HOLD; zero it otherwise so reset leaves it clean.
  assign tap_data    = tap_valid_q ? ram_rdata : '0;
  assign in_ready    = in_ready_q;
  assign tap_valid   = tap_valid_q;
  assign tap_index   = k_q;
  assign tap_channel = cur_ch_q;
  assign tap_last    = tap_last_q;
  assign err_channel = err_q;

endmodule

// File: tb/tb_fir_tap_ring.sv
module tb_fir_tap_ring;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [0:0] in_channel = '0;
  logic [7:0] in_data = '0;
  logic       flush = 1'b0;
  logic       tap_valid;
  logic       tap_ready = 1'b1;
  logic [7:0] tap_data;
  logic [1:0] tap_index;
  logic [0:0] tap_channel;
  logic       tap_last;
  logic       err_channel;

  // Three-channel instance: lets a 2-bit channel index address a missing channel.
  logic       in_valid3 = 1'b0;
  logic       in_ready3;
  logic [1:0] in_channel3 = '0;
  logic [7:0] in_data3 = '0;
  logic       tap_valid3;
  logic [7:0] tap_data3;
  logic [1:0] tap_index3;
  logic [1:0] tap_channel3;
  logic       tap_last3;
  logic       err_channel3;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fir_tap_ring #(.DWIDTH(8), .AWIDTH(2), .NCH(2)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_channel  (in_channel),
    .in_data     (in_data),
    .flush       (flush),
    .tap_valid   (tap_valid),
    .tap_ready   (tap_ready),
    .tap_data    (tap_data),
    .tap_index   (tap_index),
    .tap_channel (tap_channel),
    .tap_last    (tap_last),
    .err_channel (err_channel)
  );

  fir_tap_ring #(.DWIDTH(8), .AWIDTH(2), .NCH(3)) u_dut3 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid3),
    .in_ready    (in_ready3),
    .in_channel  (in_channel3),
    .in_data     (in_data3),
    .flush       (1'b0),
    .tap_valid   (tap_valid3),
    .tap_ready   (1'b1),
    .tap_data    (tap_data3),
    .tap_index   (tap_index3),
    .tap_channel (tap_channel3),
    .tap_last    (tap_last3),
    .err_channel (err_channel3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Offer a sample; returns at T+3 with the first tap expected valid.
  task automatic push(input logic ch, input logic [7:0] data);
    wait_ready();
    in_valid   = 1'b1;
    in_channel = ch;
    in_data    = data;
    tick();
    in_valid = 1'b0;
    check_eq("lat_t1_valid", 32'(tap_valid), 32'd0);
    check_eq("lat_t1_ready", 32'(in_ready), 32'd0);
    tick();
    check_eq("lat_t2_valid", 32'(tap_valid), 32'd0);
    tick();
    check_eq("lat_t3_valid", 32'(tap_valid), 32'd1);
  endtask

  // exp packs tap k in byte k.
  task automatic stream_from(input int start, input logic [31:0] exp, input logic ch);
    tap_ready = 1'b1;
    for (int k = start; k < 4; k++) begin
      int n = 0;
      while (!tap_valid && n < 10) begin
        tick();
        n++;
      end
      check_eq("tap_valid", 32'(tap_valid), 32'd1);
      check_eq("tap_data", 32'(tap_data), 32'(exp[8*k +: 8]));
      check_eq("tap_index", 32'(tap_index), 32'(k));
      check_eq("tap_channel", 32'(tap_channel), 32'(ch));
      check_eq("tap_last", 32'(tap_last), 32'(k == 3));
      check_eq("in_ready_mid", 32'(in_ready), 32'd0);
      tick();
    end
    check_eq("ready_after_last", 32'(in_ready), 32'd1);
    check_eq("valid_after_last", 32'(tap_valid), 32'd0);
  endtask

  task automatic check_clear(input string tag);
    for (int i = 0; i < 8; i++) begin
      check_eq({tag, "_ready_low"}, 32'(in_ready), 32'd0);
      check_eq({tag, "_no_tap"}, 32'(tap_valid), 32'd0);
      tick();
    end
    check_eq({tag, "_ready_high"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_tap_valid", 32'(tap_valid), 32'd0);
    check_eq("rst_tap_last", 32'(tap_last), 32'd0);
    check_eq("rst_err", 32'(err_channel), 32'd0);
    check_eq("rst_tap_data", 32'(tap_data), 32'd0);
    check_eq("rst_tap_index", 32'(tap_index), 32'd0);
    check_eq("rst_tap_channel", 32'(tap_channel), 32'd0);
    rst = 1'b0;
    check_clear("clr");

    // Single push, then fill ch0 past wrap
    push(1'b0, 8'h11);
    stream_from(0, 32'h0000_0011, 1'b0);
    push(1'b0, 8'h22);
    stream_from(0, 32'h0000_1122, 1'b0);
    push(1'b0, 8'h33);
    stream_from(0, 32'h0011_2233, 1'b0);
    push(1'b0, 8'h44);
    stream_from(0, 32'h1122_3344, 1'b0);
    push(1'b0, 8'h55);
    stream_from(0, 32'h2233_4455, 1'b0);

    // Flush wins over a simultaneous sample
    flush      = 1'b1;
    in_valid   = 1'b1;
    in_channel = 1'b0;
    in_data    = 8'h99;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_clear("flush");

    // Channel independence
    push(1'b0, 8'h11);
    stream_from(0, 32'h0000_0011, 1'b0);
    push(1'b1, 8'hA0);
    stream_from(0, 32'h0000_00A0, 1'b1);
    push(1'b0, 8'h22);
    stream_from(0, 32'h0000_1122, 1'b0);

    // Backpressure at index 1
    push(1'b1, 8'hB1);
    check_eq("bp_idx0_data", 32'(tap_data), 32'hB1);
    tick();
    tap_ready = 1'b0;
    check_eq("bp_issue_valid", 32'(tap_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_hold_valid", 32'(tap_valid), 32'd1);
      check_eq("bp_hold_data", 32'(tap_data), 32'hA0);
      check_eq("bp_hold_index", 32'(tap_index), 32'd1);
      check_eq("bp_hold_last", 32'(tap_last), 32'd0);
      tick();
    end
    stream_from(1, 32'h0000_A0B1, 1'b1);

    // Reset mid-stream aborts and re-clears
    push(1'b0, 8'h33);
    rst = 1'b1;
    tick();
    check_eq("mid_rst_valid", 32'(tap_valid), 32'd0);
    check_eq("mid_rst_last", 32'(tap_last), 32'd0);
    check_eq("mid_rst_data", 32'(tap_data), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    check_clear("mid_rst_clr");
    push(1'b0, 8'h44);
    stream_from(0, 32'h0000_0044, 1'b0);

    // Out-of-range channel on the three-channel instance
    check_eq("err3_idle", 32'(err_channel3), 32'd0);
    check_eq("err3_ready", 32'(in_ready3), 32'd1);
    in_valid3   = 1'b1;
    in_channel3 = 2'd3;
    in_data3    = 8'h77;
    tick();
    in_valid3 = 1'b0;
    check_eq("err3_pulse", 32'(err_channel3), 32'd1);
    check_eq("err3_stay_idle", 32'(in_ready3), 32'd1);
    tick();
    check_eq("err3_pulse_end", 32'(err_channel3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("err3_no_stream", 32'(tap_valid3), 32'd0);
      tick();
    end
    in_valid3   = 1'b1;
    in_channel3 = 2'd2;
    in_data3    = 8'h5A;
    tick();
    in_valid3 = 1'b0;
    check_eq("ch2_no_err", 32'(err_channel3), 32'd0);
    tick();
    tick();
    check_eq("ch2_valid", 32'(tap_valid3), 32'd1);
    check_eq("ch2_data", 32'(tap_data3), 32'h5A);
    check_eq("ch2_channel", 32'(tap_channel3), 32'd2);
    check_eq("ch2_index", 32'(tap_index3), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_tap_ring.md
FIR_TAP_RING -- requirements
Module: fir_tap_ring

Interface
REQ-001 SHALL have parameter DWIDTH, default 8, sample width in bits.
REQ-002 SHALL have parameter AWIDTH, default 4, log2 of taps per channel; DEPTH = 2**AWIDTH.
REQ-003 SHALL have parameter NCH, default 2, channel count (>=1); CHW = max(1, clog2(NCH)).
REQ-004 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_valid  input  1  new sample offered.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port in_channel  input  CHW  target channel of the offered sample.
REQ-009 SHALL have port in_data  input  DWIDTH  offered sample.
REQ-010 SHALL have port flush  input  1  zero all history and pointers (sampled in IDLE only).
REQ-011 SHALL have port tap_valid  output  1  tap_data/tap_index/tap_channel/tap_last valid.
REQ-012 SHALL have port tap_ready  input  1  consumer accepts the current tap.
REQ-013 SHALL have port tap_data  output  DWIDTH  delayed sample x[n-k].
REQ-014 SHALL have port tap_index  output  AWIDTH  delay k of tap_data.
REQ-015 SHALL have port tap_channel  output  CHW  channel of the stream.
REQ-016 SHALL have port tap_last  output  1  high with k = DEPTH-1.
REQ-017 SHALL have port err_channel  output  1  one-cycle pulse: sample with in_channel >= NCH dropped.

Function
REQ-018 SHALL store NCH*DEPTH samples in one single-port RAM at address ch*DEPTH + slot, 1-cycle read latency.
REQ-019 SHALL keep a per-channel AWIDTH-bit write pointer wptr[ch], wrapping DEPTH-1 -> 0.
REQ-020 SHALL implement FSM states CLEAR, IDLE, WRITE, RD_ISSUE, RD_HOLD.
REQ-021 CLEAR: write zero to one address per cycle, 0 .. NCH*DEPTH-1 (NCH*DEPTH cycles), zero all wptr, then IDLE; in_ready=0.
REQ-022 IDLE: in_ready=1; flush=1 -> CLEAR (flush has priority over in_valid, sample not accepted).
REQ-023 IDLE, in_valid=1, in_channel < NCH (cycle T): capture sample/channel -> WRITE (T+1) writes to wptr[ch], then wptr[ch] increments.
REQ-024 IDLE, in_valid=1, in_channel >= NCH: accept, drop sample, err_channel=1 at T+1, stay IDLE.
REQ-025 After WRITE, SHALL stream k = 0 .. DEPTH-1, tap address ch*DEPTH + ((slot_written - k) mod DEPTH), newest first.
REQ-026 RD_ISSUE presents address (1 cycle) -> RD_HOLD with tap_valid=1; first tap_valid at T+3.
REQ-027 RD_HOLD: all tap outputs held stable while tap_ready=0; tap_ready=1 -> RD_ISSUE for k+1, or IDLE when tap_last.
REQ-028 With tap_ready tied high, stream SHALL take 2*DEPTH cycles; in_ready returns high the cycle after the last handshake.
REQ-029 in_ready SHALL be 0 in every state except IDLE; no sample accepted mid-stream.
REQ-030 Channels SHALL be independent: a write to channel a never alters history or wptr of channel b.

Reset
REQ-031 rst=1 SHALL force, next edge: state CLEAR, clear address 0, in_ready=0, tap_valid=0, tap_last=0, err_channel=0, tap_data/tap_index/tap_channel=0.
REQ-032 rst mid-stream or mid-CLEAR SHALL abort and restart a full CLEAR; no partial stream resumes.

Structure
REQ-033 SHALL place the FSM state enum and a clog2-based CHW helper in shared package fir_pkg.
REQ-034 SHALL instantiate one sub-module, sample_ram (single-port, DWIDTH x NCH*DEPTH, registered read).

Verification (DWIDTH=8, AWIDTH=2, NCH=2)
REQ-035 Release rst -> in_ready low exactly 8 cycles, then high; no tap_valid during clear.
REQ-036 Push ch0 0x11 at T -> tap_valid at T+3; taps 0x11,0x00,0x00,0x00, idx 0..3, tap_last on idx 3.
REQ-037 Push ch0 0x11,0x22,0x33,0x44,0x55 -> fifth stream 0x55,0x44,0x33,0x22 (wrap).
REQ-038 ch0 0x11, ch1 0xA0, ch0 0x22 -> ch1 stream 0xA0,0,0,0; last ch0 stream 0x22,0x11,0,0, tap_channel correct.
REQ-039 tap_ready low 5 cycles at idx 1 -> tap_data/tap_index unchanged, stream resumes at idx 1.
REQ-040 in_channel=3 -> err_channel pulse, no stream; flush after data -> 8-cycle clear, then ch0 push streams x,0,0,0; rst mid-stream -> tap_valid 0 next cycle.
